cmd_parallel_serial_tx: RTL and testbench

Parallel-to-serial transmitter for the SD host CMD path. It captures an n-bit command word on a load strobe and shifts it out MSB-first, one bit per enabled sd_clock edge. It drives the CMD line output-enable for the tristate pad and signals a one-cycle completion pulse. It is the transmit-side counterpart of the CMD serial-to-parallel receiver and sits between the command builder and the CMD pad.

---
 rtl/cmd_parallel_serial_tx.sv | 111 +++++++++++
 tb/tb_cmd_parallel_serial_tx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_parallel_serial_tx.sv
// cmd_parallel_serial_tx
// SD host CMD-path parallel-to-serial transmitter. A command word is captured
// on an accepted load and shifted out MSB-first, one bit per enabled edge.
// The pad output-enable, busy flag and completion pulse are all registered.
module cmd_parallel_serial_tx #(
   parameter int n = 48
) (
   input  logic         sd_clock,
   input  logic         reset,
   input  logic [n-1:0] parallel,
   input  logic         load,
   input  logic         enable,
   output logic         serial,
   output logic         serial_oe,
   output logic         busy,
   output logic         complete
);

   localparam int CW = (n > 1) ? $clog2(n) : 1;
   localparam logic [CW-1:0] LAST = CW'(n - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [n-1:0]  shreg_q, shreg_d;
   logic [CW-1:0] count_q, count_d;
   logic          serial_d, oe_d, busy_d, complete_d;

   // State and registered outputs; synchronous reset has top priority.
   always_ff @(posedge sd_clock) begin
      if (reset) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         count_q   <= '0;
         serial    <= 1'b1;
         serial_oe <= 1'b0;
         busy      <= 1'b0;
         complete  <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         count_q   <= count_d;
         serial    <= serial_d;
         serial_oe <= oe_d;
         busy      <= busy_d;
         complete  <= complete_d;
      end
   end

   // Next-state and next-output logic; everything holds unless a rule fires.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      count_d    = count_q;
      serial_d   = serial;
      oe_d       = serial_oe;
      busy_d     = busy;
      complete_d = complete;

      case (state_q)
         IDLE: begin
            if (load) begin
               shreg_d    = parallel;
               count_d    = '0;
               serial_d   = parallel[n-1];
               oe_d       = 1'b1;
               busy_d     = 1'b1;
               complete_d = 1'b0;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            if (enable) begin
               if (count_q != LAST) begin
                  // The word is shifted left on each advance, so the next bit
                  // to drive (original bit n-2-count) is always the new MSB.
                  count_d  = count_q + CW'(1);
                  shreg_d  = shreg_q << 1;
                  serial_d = shreg_d[n-1];
               end else begin
                  serial_d   = 1'b1;
                  oe_d       = 1'b0;
                  complete_d = 1'b1;
                  state_d    = DONE;
               end
            end
         end
         DONE: begin
            serial_d   = 1'b1;
            oe_d       = 1'b0;
            busy_d     = 1'b0;
            complete_d = 1'b0;
            state_d    = IDLE;
         end
         default: begin
            state_d    = IDLE;
            shreg_d    = '0;
            count_d    = '0;
            serial_d   = 1'b1;
            oe_d       = 1'b0;
            busy_d     = 1'b0;
            complete_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_cmd_parallel_serial_tx.sv
// tb_cmd_parallel_serial_tx
// Self-checking bench: each word's expected CMD-line trace is built from the
// word bits and a per-bit stall count (each bit lasts 1 + stalls cycles,
// followed by one DONE cycle and then idle), independent of the RTL structure.
module tb_cmd_parallel_serial_tx;

   localparam int N = 48;

   logic         sd_clock = 1'b0;
   logic         reset    = 1'b1;
   logic [N-1:0] parallel = '0;
   logic         load     = 1'b0;
   logic         enable   = 1'b0;
   logic         serial, serial_oe, busy, complete;

   logic         parallel1 = 1'b0;
   logic         load1     = 1'b0;
   logic         enable1   = 1'b0;
   logic         serial1, serial_oe1, busy1, complete1;

   int total = 0;
   int bad   = 0;

   // expected/observed traces as {serial, serial_oe, busy, complete}
   logic [3:0] exp_q[$];
   logic [3:0] obs_q[$];
   int         stall_cfg[N];

   cmd_parallel_serial_tx #(.n(N)) u_dut (
      .sd_clock  (sd_clock),
      .reset     (reset),
      .parallel  (parallel),
      .load      (load),
      .enable    (enable),
      .serial    (serial),
      .serial_oe (serial_oe),
      .busy      (busy),
      .complete  (complete)
   );

   cmd_parallel_serial_tx #(.n(1)) u_dut1 (
      .sd_clock  (sd_clock),
      .reset     (reset),
      .parallel  (parallel1),
      .load      (load1),
      .enable    (enable1),
      .serial    (serial1),
      .serial_oe (serial_oe1),
      .busy      (busy1),
      .complete  (complete1)
   );

   // free-running shift clock
   always #5 sd_clock = ~sd_clock;

   // absolute run-time limit
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge sd_clock);
      #1;
   endtask

   function automatic logic [3:0] outs();
      return {serial, serial_oe, busy, complete};
   endfunction

   function automatic logic [3:0] outs1();
      return {serial1, serial_oe1, busy1, complete1};
   endfunction

   // Drive one word and record the trace. Positions: 0 = cycle after the load
   // edge; bits fill positions 0..L-1, L is DONE, L+1 is idle.
   task automatic run_word(input logic [N-1:0] w, input bit hold_load,
                           input int junk_pos, input bit junk_done,
                           input int rst_pos);
      logic en_q[$];
      int   len;
      exp_q.delete();
      obs_q.delete();
      for (int b = N - 1; b >= 0; b--) begin
         for (int k = 0; k <= stall_cfg[b]; k++) begin
            exp_q.push_back({w[b], 3'b110});
            en_q.push_back(k == stall_cfg[b]);
         end
      end
      len = en_q.size();
      exp_q.push_back(4'b1011);
      exp_q.push_back(4'b1000);
      if (rst_pos >= 0) begin
         while (exp_q.size() > rst_pos + 1) void'(exp_q.pop_back());
         exp_q.push_back(4'b1000);
         exp_q.push_back(4'b1000);
      end

      parallel = w;
      load     = 1'b1;
      enable   = 1'($urandom_range(0, 1));
      tick();
      obs_q.push_back(outs());
      for (int p = 0; p < exp_q.size() - 1; p++) begin
         parallel = N'({$urandom, $urandom});
         load     = hold_load;
         if (p == junk_pos || (junk_done && p == len)) begin
            load     = 1'b1;
            parallel = '1;
         end
         enable = (p < len) ? en_q[p] : 1'($urandom_range(0, 1));
         reset  = (p == rst_pos);
         tick();
         obs_q.push_back(outs());
      end
      reset = 1'b0;
      if (!hold_load) load = 1'b0;
   endtask

   function automatic void clear_stalls();
      for (int b = 0; b < N; b++) stall_cfg[b] = 0;
   endfunction

   task automatic test_reset();
      reset  = 1'b1;
      load   = 1'b1;
      load1  = 1'b1;
      enable = 1'b1;
      parallel = 48'h400000000095;
      for (int c = 0; c < 2; c++) begin
         tick();
         total++;
         if (outs() !== 4'b1000) begin
            bad++;
            $display("FAIL reset_hold cyc=%0d got=%b want=1000", c, outs());
         end
         total++;
         if (outs1() !== 4'b1000) begin
            bad++;
            $display("FAIL reset_hold_n1 cyc=%0d got=%b want=1000", c, outs1());
         end
      end
      reset = 1'b0;
      load  = 1'b0;
      load1 = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         total++;
         if (outs() !== 4'b1000) begin
            bad++;
            $display("FAIL reset_release cyc=%0d got=%b want=1000", c, outs());
         end
      end
   endtask

   task automatic test_fixed_word();
      clear_stalls();
      run_word(48'h400000000095, 1'b0, -1, 1'b0, -1);
      foreach (exp_q[i]) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL fixed_word pos=%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_stall();
      clear_stalls();
      stall_cfg[37] = 3;
      run_word(48'h400000000095, 1'b0, -1, 1'b0, -1);
      foreach (exp_q[i]) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL stall pos=%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_load_ignored();
      clear_stalls();
      run_word(48'h400000000095, 1'b0, 10, 1'b1, -1);
      foreach (exp_q[i]) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL load_ignored pos=%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_stalls();
      run_word(48'h400000000095, 1'b0, -1, 1'b0, 20);
      foreach (exp_q[i]) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL reset_mid pos=%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
         end
      end
      run_word(48'h7A0000000001, 1'b0, -1, 1'b0, -1);
      foreach (exp_q[i]) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL after_reset_word pos=%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_stalls();
      for (int w = 0; w < 3; w++) begin
         run_word(N'({$urandom, $urandom}), 1'b1, -1, 1'b0, -1);
         foreach (exp_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
               bad++;
               $display("FAIL back_to_back word=%0d pos=%0d got=%b want=%b", w, i, obs_q[i], exp_q[i]);
            end
         end
      end
      load = 1'b0;
      tick();
   endtask

   task automatic test_random();
      for (int w = 0; w < 4; w++) begin
         for (int b = 0; b < N; b++)
            stall_cfg[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         run_word(N'({$urandom, $urandom}), 1'($urandom_range(0, 1)), -1, 1'b0, -1);
         foreach (exp_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
               bad++;
               $display("FAIL random word=%0d pos=%0d got=%b want=%b", w, i, obs_q[i], exp_q[i]);
            end
         end
         load = 1'b0;
         tick();
      end
   endtask

   task automatic test_n1();
      for (int v = 0; v < 2; v++) begin
         parallel1 = 1'(v);
         load1     = 1'b1;
         enable1   = 1'b1;
         tick();
         total++;
         if (outs1() !== {1'(v), 3'b110}) begin
            bad++;
            $display("FAIL n1_load v=%0d got=%b want=%b", v, outs1(), {1'(v), 3'b110});
         end
         load1     = 1'b0;
         enable1   = 1'b0;
         parallel1 = ~parallel1;
         tick();
         total++;
         if (outs1() !== {1'(v), 3'b110}) begin
            bad++;
            $display("FAIL n1_stall v=%0d got=%b want=%b", v, outs1(), {1'(v), 3'b110});
         end
         enable1 = 1'b1;
         tick();
         total++;
         if (outs1() !== 4'b1011) begin
            bad++;
            $display("FAIL n1_done v=%0d got=%b want=1011", v, outs1());
         end
         tick();
         total++;
         if (outs1() !== 4'b1000) begin
            bad++;
            $display("FAIL n1_idle v=%0d got=%b want=1000", v, outs1());
         end
      end
   endtask

   initial begin
      test_reset();
      test_fixed_word();
      test_stall();
      test_load_ignored();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_n1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
